// File: rtl/tipi_pi_bus_pkg.sv
// Shared definitions for the TIPI N-bit Pi bus: transfer select codes and FSM states.
package tipi_pi_bus_pkg;

  typedef enum logic [1:0] {
    SEL_TD = 2'd0,
    SEL_TC = 2'd1,
    SEL_RD = 2'd2,
    SEL_RC = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Select codes with bit 1 set move data from the Pi into the block.
  function automatic logic sel_is_write(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/tipi_nbit_pi_bus_if.sv
// Register-side signals of the Pi bus: TI registers in, Pi registers and event toggles out.
interface tipi_nbit_pi_bus_if #(
  parameter int REG_W = 8
);
  logic [REG_W-1:0] TD;
  logic [REG_W-1:0] TC;
  logic [REG_W-1:0] RD;
  logic [REG_W-1:0] RC;
  logic             td_tgl;
  logic             tc_tgl;
  logic             rd_tgl;
  logic             rc_tgl;
  logic             busy;

  modport slave (
    input  TD, TC,
    output RD, RC, td_tgl, tc_tgl, rd_tgl, rc_tgl, busy
  );

  modport master (
    output TD, TC,
    input  RD, RC, td_tgl, tc_tgl, rd_tgl, rc_tgl, busy
  );
endinterface

// File: rtl/tipi_pi_beat_shifter.sv
// Beat counter plus read snapshot (shift-out) and write accumulator (shift-in), MSB beat first.
module tipi_pi_beat_shifter #(
  parameter int BUS_W = 4,
  parameter int REG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_read,
  input  logic             clear_write,
  input  logic             shift_read,
  input  logic             shift_write,
  input  logic [REG_W-1:0] load_word,
  input  logic [BUS_W-1:0] din,
  output logic [BUS_W-1:0] dout,
  output logic [REG_W-1:0] acc_word,
  output logic             last
);

  localparam int NBEATS = REG_W / BUS_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  logic [BEAT_W-1:0] beat;
  logic [REG_W-1:0]  snap;
  logic [REG_W-1:0]  acc;

  assign last     = (beat == LAST_BEAT);
  assign dout     = snap[REG_W-1 -: BUS_W];
  // Word as it stands after this edge's beat; the top commits it on the last beat.
  assign acc_word = (acc << BUS_W) | REG_W'(din);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= '0;
      snap <= '0;
      acc  <= '0;
    end else begin
      if (load_read || clear_write) begin
        beat <= '0;
      end else if (shift_read || shift_write) begin
        beat <= last ? '0 : beat + 1'b1;
      end

      if (load_read) begin
        snap <= load_word;
      end else if (shift_read) begin
        snap <= snap << BUS_W;
      end

      if (clear_write) begin
        acc <= '0;
      end else if (shift_write) begin
        acc <= acc_word;
      end
    end
  end

endmodule

// File: rtl/tipi_nbit_pi_bus.sv
// Pi-facing beat-serial port: atomic snapshot reads of TD/TC, atomic commits to RD/RC.
module tipi_nbit_pi_bus
  import tipi_pi_bus_pkg::*;
#(
  parameter int BUS_W = 4,
  parameter int REG_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire  [BUS_W-1:0]     data,
  tipi_nbit_pi_bus_if.slave    bus
);

  if (BUS_W < 2 || BUS_W > 8 || REG_W < BUS_W || (REG_W % BUS_W) != 0) begin : g_param_err
    $error("tipi_nbit_pi_bus: illegal BUS_W=%0d / REG_W=%0d", BUS_W, REG_W);
  end

  state_t           state;
  sel_t             sel;
  logic             oe;
  logic             busy_q;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] rc_q;
  logic             td_tgl_q;
  logic             tc_tgl_q;
  logic             rd_tgl_q;
  logic             rc_tgl_q;

  logic             idle;
  logic             req_write;
  logic [BUS_W-1:0] dout;
  logic [REG_W-1:0] acc_word;
  logic             last;
  logic [REG_W-1:0] snap_src;

  assign idle      = (state == IDLE);
  assign req_write = sel_is_write(data[1:0]);
  assign snap_src  = data[0] ? bus.TC : bus.TD;

  tipi_pi_beat_shifter #(
    .BUS_W (BUS_W),
    .REG_W (REG_W)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load_read   (idle && !req_write),
    .clear_write (idle && req_write),
    .shift_read  (state == READ),
    .shift_write (state == WRITE),
    .load_word   (snap_src),
    .din         (data),
    .dout        (dout),
    .acc_word    (acc_word),
    .last        (last)
  );

  // oe is registered so the first beat appears right after the select edge
  // and the bus is released on the final read edge.
  assign data = oe ? dout : {BUS_W{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= SEL_TD;
      oe       <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= '0;
      rc_q     <= '0;
      td_tgl_q <= 1'b0;
      tc_tgl_q <= 1'b0;
      rd_tgl_q <= 1'b0;
      rc_tgl_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sel    <= sel_t'(data[1:0]);
          busy_q <= 1'b1;
          oe     <= !req_write;
          state  <= req_write ? WRITE : READ;
        end
        READ: begin
          if (last) begin
            state  <= IDLE;
            oe     <= 1'b0;
            busy_q <= 1'b0;
            if (sel == SEL_TC) tc_tgl_q <= ~tc_tgl_q;
            else               td_tgl_q <= ~td_tgl_q;
          end
        end
        WRITE: begin
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (sel == SEL_RC) begin
              rc_q     <= acc_word;
              rc_tgl_q <= ~rc_tgl_q;
            end else begin
              rd_q     <= acc_word;
              rd_tgl_q <= ~rd_tgl_q;
            end
          end
        end
        default: begin
          state  <= IDLE;
          oe     <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RD     = rd_q;
  assign bus.RC     = rc_q;
  assign bus.td_tgl = td_tgl_q;
  assign bus.tc_tgl = tc_tgl_q;
  assign bus.rd_tgl = rd_tgl_q;
  assign bus.rc_tgl = rc_tgl_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_tipi_nbit_pi_bus.sv
// Directed bench for tipi_nbit_pi_bus at 4/8 and 2/16 widths; released bus reads as all ones via pullups.
module tb_tipi_nbit_pi_bus;

  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic reset = 1'b0;

  logic       oe_a = 1'b0;
  logic [3:0] drv_a = '0;
  wire  [3:0] data_a;
  logic       oe_b = 1'b0;
  logic [1:0] drv_b = '0;
  wire  [1:0] data_b;

  int n_checks = 0;
  int n_errors = 0;

  assign data_a = oe_a ? drv_a : 4'bzzzz;
  assign data_b = oe_b ? drv_b : 2'bzz;

  for (genvar i = 0; i < 4; i++) begin : g_pu_a
    pullup (data_a[i]);
  end
  for (genvar i = 0; i < 2; i++) begin : g_pu_b
    pullup (data_b[i]);
  end

  tipi_nbit_pi_bus_if #(.REG_W(8))  bus_a ();
  tipi_nbit_pi_bus_if #(.REG_W(16)) bus_b ();

  tipi_nbit_pi_bus #(.BUS_W(4), .REG_W(8)) u_dut_a (
    .clk   (clk_a),
    .reset (reset),
    .data  (data_a),
    .bus   (bus_a.slave)
  );

  tipi_nbit_pi_bus #(.BUS_W(2), .REG_W(16)) u_dut_b (
    .clk   (clk_b),
    .reset (reset),
    .data  (data_b),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One Pi strobe: optionally drive a beat, rise, release, fall; outputs are sampled afterwards.
  task automatic tick_a(input bit drive, input logic [3:0] v);
    oe_a = drive; drv_a = v;
    #2 clk_a = 1'b1;
    #1 oe_a = 1'b0;
    #2 clk_a = 1'b0;
    #5;
  endtask

  task automatic tick_b(input bit drive, input logic [1:0] v);
    oe_b = drive; drv_b = v;
    #2 clk_b = 1'b1;
    #1 oe_b = 1'b0;
    #2 clk_b = 1'b0;
    #5;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    #1;
  endtask

  logic [1:0] beats_b [8] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    bus_a.TD = 8'hA5;
    bus_a.TC = 8'h5A;
    bus_b.TD = 16'h9C1B;
    bus_b.TC = 16'h0000;
    pulse_reset();

    check("rst_rd", bus_a.RD, 8'h00);
    check("rst_rc", bus_a.RC, 8'h00);
    check("rst_tgls", {bus_a.td_tgl, bus_a.tc_tgl, bus_a.rd_tgl, bus_a.rc_tgl}, 4'b0000);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_data_z", data_a, 4'hF);

    // Read TD = A5
    tick_a(1'b1, 4'h0);
    check("rd_td_beat0", data_a, 4'hA);
    check("rd_td_busy", bus_a.busy, 1'b1);
    tick_a(1'b0, 4'h0);
    check("rd_td_beat1", data_a, 4'h5);
    check("rd_td_tgl_hold", bus_a.td_tgl, 1'b0);
    tick_a(1'b0, 4'h0);
    check("rd_td_release", data_a, 4'hF);
    check("rd_td_tgl", bus_a.td_tgl, 1'b1);
    check("rd_td_busy_end", bus_a.busy, 1'b0);

    // Read TC = 5A, TC changes mid-transfer
    tick_a(1'b1, 4'h1);
    bus_a.TC = 8'hFF;
    check("rd_tc_beat0", data_a, 4'h5);
    tick_a(1'b0, 4'h0);
    check("rd_tc_beat1", data_a, 4'hA);
    tick_a(1'b0, 4'h0);
    check("rd_tc_release", data_a, 4'hF);
    check("rd_tc_tgl", bus_a.tc_tgl, 1'b1);
    check("rd_tc_td_tgl_kept", bus_a.td_tgl, 1'b1);

    // Write RD = A5
    tick_a(1'b1, 4'h2);
    tick_a(1'b1, 4'hA);
    check("wr_rd_partial", bus_a.RD, 8'h00);
    check("wr_rd_busy", bus_a.busy, 1'b1);
    tick_a(1'b1, 4'h5);
    check("wr_rd_commit", bus_a.RD, 8'hA5);
    check("wr_rd_tgl", bus_a.rd_tgl, 1'b1);
    check("wr_rd_busy_end", bus_a.busy, 1'b0);

    // Write RC = 5A
    tick_a(1'b1, 4'h3);
    tick_a(1'b1, 4'h5);
    tick_a(1'b1, 4'hA);
    check("wr_rc_commit", bus_a.RC, 8'h5A);
    check("wr_rc_tgl", bus_a.rc_tgl, 1'b1);
    check("wr_rc_rd_kept", bus_a.RD, 8'hA5);

    // Abandoned write of RC
    tick_a(1'b1, 4'h3);
    tick_a(1'b1, 4'hF);
    check("abort_busy_pre", bus_a.busy, 1'b1);
    pulse_reset();
    check("abort_rc", bus_a.RC, 8'h00);
    check("abort_rc_tgl", bus_a.rc_tgl, 1'b0);
    check("abort_data_z", data_a, 4'hF);
    check("abort_busy", bus_a.busy, 1'b0);

    // Back-to-back writes 11 then 22
    tick_a(1'b1, 4'h2);
    tick_a(1'b1, 4'h1);
    tick_a(1'b1, 4'h1);
    check("b2b_first", bus_a.RD, 8'h11);
    check("b2b_tgl1", bus_a.rd_tgl, 1'b1);
    tick_a(1'b1, 4'h2);
    tick_a(1'b1, 4'h2);
    tick_a(1'b1, 4'h2);
    check("b2b_second", bus_a.RD, 8'h22);
    check("b2b_tgl2", bus_a.rd_tgl, 1'b0);

    // 2-bit bus, 16-bit register: write RD = 9C1B
    tick_b(1'b1, 2'd2);
    for (int i = 0; i < 8; i++) begin
      tick_b(1'b1, beats_b[i]);
      if (i == 6) check("w16_partial", bus_b.RD, 16'h0000);
    end
    check("w16_commit", bus_b.RD, 16'h9C1B);
    check("w16_tgl", bus_b.rd_tgl, 1'b1);
    check("w16_busy_end", bus_b.busy, 1'b0);

    // Read back TD = 9C1B as the same eight beats
    tick_b(1'b1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("r16_beat%0d", i), data_b, beats_b[i]);
      tick_b(1'b0, 2'd0);
    end
    check("r16_tgl", bus_b.td_tgl, 1'b1);
    check("r16_busy_end", bus_b.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tipi_nbit_pi_bus.md
# tipi_nbit_pi_bus

Parametrised successor to the 4-bit Pi bus: a synchronous nibble/beat-serial port through which the Raspberry Pi reads the TI-side TD/TC registers and writes the Pi-side RD/RC registers over a narrow bidirectional bus. Bus width and register width are generic. Reads are snapshot-atomic, writes commit atomically on the last beat, and per-register toggle flags let the TI-side logic detect completed transfers across the clock boundary. The block sits between the Pi GPIO header and the TIPI CPLD register file.

## Interface
- BUS_W, 4, bus beat width in bits; legal range 2..8.
- REG_W, 8, register width; must be a multiple of BUS_W and at least BUS_W.
- NBEATS, REG_W/BUS_W, derived localparam; not overridable.

- clk  in  1  Pi-driven transfer strobe; all state advances on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- data  inout  BUS_W  bidirectional beat bus; driven only in READ, Z otherwise.
- TD  in  REG_W  TI data register presented for Pi reads.
- TC  in  REG_W  TI control register presented for Pi reads.
- RD  out  REG_W  Pi data register.
- RC  out  REG_W  Pi control register.
- td_tgl  out  1  toggles when a TD read completes.
- tc_tgl  out  1  toggles when a TC read completes.
- rd_tgl  out  1  toggles when an RD write commits.
- rc_tgl  out  1  toggles when an RC write commits.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, READ, WRITE. Beat counter runs 0..NBEATS-1. Latched select is 2 bits.
- IDLE: data is Z. On a clk edge, the block samples data[1:0] as the select; data[BUS_W-1:2] is ignored.
  - Select 0 or 1: snapshot TD or TC into the shift register, set beat to 0, go to READ.
  - Select 2 or 3: clear the accumulator, set beat to 0, go to WRITE.
- READ: data drives snapshot[REG_W-1-beat*BUS_W -: BUS_W], MSB beat first.
  - Each edge increments beat.
  - On the edge with beat = NBEATS-1: go to IDLE, release data, toggle td_tgl or tc_tgl.
  - TD/TC changes during READ do not affect the beats being sent.
- WRITE: each edge shifts data into the accumulator, MSB beat first.
  - On the edge with beat = NBEATS-1: RD or RC is loaded with the full word in the same edge, the matching toggle flips, and the state goes to IDLE.
  - RD/RC never show a partial value.
- Reset values: RD = 0, RC = 0, all toggles 0, busy 0, data Z, state IDLE, beat 0, snapshot and accumulator 0.
- Reset asserted mid-transfer: the transfer is abandoned immediately. A partial write is discarded (RD/RC go to 0 via reset) and no toggle flips.
- Parameter violations (REG_W % BUS_W ≠ 0, BUS_W < 2) cause an elaboration-time $error.

## Timing
- A read takes 1 select edge plus NBEATS edges. A write takes the same count.
- First read beat is valid on data within combinational delay after the select edge. No dead cycle.
- Each subsequent beat is valid after the edge that advances it. The Pi samples before its next rising edge.
- Output enable deasserts on the final read edge, so the bus is Z before the Pi drives the next select.
- RD/RC and the toggles update on the committing edge and hold until the next commit or reset.
- busy rises on the select edge and falls on the final edge.

## Structure
- Shared package/include `tipi_pi_bus_pkg`:
  - select codes SEL_TD=0, SEL_TC=1, SEL_RD=2, SEL_RC=3;
  - state encoding IDLE/READ/WRITE.
- One sub-module, `tipi_pi_beat_shifter` (parameters BUS_W, REG_W), containing:
  - the beat counter with last-beat flag;
  - a parallel-load/shift-out register for reads;
  - a shift-in accumulator for writes.
- The top level holds the FSM, the tri-state driver, RD/RC and the toggles.

## Test plan
- Default params, TD=8'hA5, select 0 then 2 edges:
  - data shows 4'hA after the select edge, then 4'h5;
  - data is Z after the final edge; td_tgl goes 0→1.
- TC=8'h5A, select 1; change TC to 8'hFF after the select edge:
  - data still reads 4'h5 then 4'hA; tc_tgl toggles.
- Select 2, beats 4'hA then 4'h5:
  - RD stays 0 after the first beat, becomes 8'hA5 on the second edge;
  - rd_tgl toggles; busy falls.
- Select 3, beats 4'h5 then 4'hA:
  - RC = 8'h5A, rc_tgl toggles.
  - Then select 3, one beat 4'hF, assert reset: RC = 0, rc_tgl = 0, data Z, busy 0.
- BUS_W=2, REG_W=16:
  - select 2 then 8 beats 2,1,3,0,0,1,2,3 → RD = 16'h9C1B after the 8th beat only;
  - read-back of TD=16'h9C1B via select 0 yields the same 8 beats.
- Back-to-back writes RD=8'h11 then RD=8'h22 with no idle edge between:
  - rd_tgl toggles twice; final RD = 8'h22.
